wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline write-back
//  (wb_enable/wb_rd/wb_data from the WB stage) and the long-latency multiply/divide unit (MDU).
//  The pipeline has priority. MDU results wait in a small FIFO. A starvation timer forces a
//  one-cycle pipeline stall so a buffered result can drain. Sits between WB stage, MDU and regfile.
// PARAMETERS
//  XLEN      32  data width of register writes
//  DEPTH     2   MDU result FIFO entries; power of 2, >=2
//  MAX_WAIT  4   consecutive denied cycles of FIFO head before stall is forced; >=1
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        reset, synchronous, active-low
//  wb_enable     in   1        pipeline write request (WB stage reg_write)
//  wb_rd         in   5        pipeline destination register
//  wb_data       in   XLEN     pipeline write data
//  mdu_valid     in   1        MDU result valid
//  mdu_rd        in   5        MDU destination register
//  mdu_data      in   XLEN     MDU result
//  mdu_ready     out  1        arbiter accepts MDU result this cycle
//  rf_we         out  1        regfile write enable
//  rf_rd         out  5        regfile write address
//  rf_wdata      out  XLEN     regfile write data
//  stall_o       out  1        freeze pipeline; WB stage holds and re-presents its write next cycle
//  pending_mask  out  32       bit r = 1 iff a buffered MDU result targets x[r]; to hazard unit
// BEHAVIOUR
//  - Reset: all state is cleared at the edge where rst_n=0: FIFO count/pointers=0, wait_cnt=0,
//    stall_o=0. While rst_n=0: mdu_ready=0, rf_we=0, rf_rd=0, rf_wdata=0, pending_mask=0.
//    Reset mid-operation discards buffered entries; they are never written.
//  - Accept: mdu_ready = !full (from registered count; independent of mdu_valid).
//    A transfer is mdu_valid&&mdu_ready at a clk edge. mdu_rd==0 transfers are accepted and
//    discarded, not enqueued. When the FIFO is full, mdu_ready=0, even if a dequeue
//    happens in the same cycle.
//  - No bypass: an entry enqueued at edge N can write no earlier than cycle N+1.
//  - Port select each cycle (combinational; zero latency for the pipeline path), first match wins:
//    1) stall_o=1 -> FIFO head written and dequeued; the pipeline request is ignored, because
//       the pipeline repeats it.
//    2) wb_enable && wb_rd!=0 -> pipeline write; rf_* = wb_*.
//    3) FIFO non-empty -> head written and dequeued.
//    4) else rf_we=0, rf_rd=0, rf_wdata=0.
//    wb_enable with wb_rd==0 counts as no request, so the FIFO may drain that cycle.
//  - Starvation: wait_cnt counts consecutive cycles with FIFO non-empty and head not dequeued.
//    It clears on any dequeue or when the FIFO is empty. If wait_cnt==MAX_WAIT-1 and the head is
//    denied again, stall_o=1 in the next cycle for exactly one cycle, and wait_cnt clears.
//    stall_o is never high in two consecutive cycles.
//  - Simultaneous enqueue and dequeue on a non-full FIFO: both occur; count is unchanged.
//  - FIFO order is strict; entries are written oldest first.
//  - pending_mask is combinational from valid FIFO entries; bit0 is always 0.
//    Overlapping rd entries OR together.
//  - WAW between buffered MDU results and younger pipeline writes is prevented upstream by the
//    hazard unit using pending_mask; the arbiter does not reorder or kill entries.
// STRUCTURE
//  - Package wb_arb_pkg: XLEN default, REG_ADDR_W=5, typedef struct packed {logic [4:0] rd;
//    logic [XLEN-1:0] data;} wb_req_t, and enum typedef wb_src_e {SRC_NONE, SRC_PIPE, SRC_MDU}.
//  - Sub-module wb_req_fifo: synchronous DEPTH-entry FIFO of wb_req_t.
//    It has push/pop/full/empty and exposes all entries for pending_mask.
//  - Top level: select logic, wait counter, stall flop.
// TESTING
//  1. wb_enable=1, wb_rd=5, wb_data=0xDEADBEEF, MDU idle -> same cycle rf_we=1, rf_rd=5,
//     rf_wdata=0xDEADBEEF; stall_o=0.
//  2. Pipeline idle; mdu_valid, rd=7, data=0x12 accepted at edge N -> pending_mask[7]=1 in N+1;
//     rf write x7=0x12 in N+1; mask 0 in N+2.
//  3. Pipeline writes every cycle; MDU offers 3 results -> first 2 accepted; mdu_ready=0
//     afterwards; third held until a slot frees.
//  4. MAX_WAIT=4, pipeline writes every cycle, one entry enqueued at N -> stall_o=1 only in N+5;
//     head written in N+5; the pipeline write is repeated and written in N+6.
//  5. FIFO holds rd=9; pipeline wb_enable=1, wb_rd=0 -> head written that cycle.
//     MDU result with rd=0 is accepted and never written.
//  6. FIFO full (2 entries), rst_n=0 for one cycle -> afterwards pending_mask=0, mdu_ready=1,
//     no write of old entries.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: request record and
// write-source select.
package wb_arb_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MDU
  } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of WB-stage, MDU and regfile signals around the write-port arbiter.
// The arbiter takes the slave side; the pipeline/MDU/regfile environment takes the master side.
interface wb_port_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);

  logic                  wb_enable;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;

  logic                  mdu_valid;
  logic [REG_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]       mdu_data;
  logic                  mdu_ready;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_wdata;

  logic                  stall_o;
  logic [31:0]           pending_mask;

  modport slave (
    input  wb_enable, wb_rd, wb_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready,
    output rf_we, rf_rd, rf_wdata,
    output stall_o, pending_mask
  );

  modport master (
    output wb_enable, wb_rd, wb_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready,
    input  rf_we, rf_rd, rf_wdata,
    input  stall_o, pending_mask
  );

endinterface

// File: rtl/wb_req_fifo.sv
// DEPTH-entry synchronous FIFO of buffered MDU write requests. Per-entry valid
// bits and rd fields are exposed so the top can build the pending-register mask.
module wb_req_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entry_vld,
  output logic [REG_ADDR_W-1:0] entry_rd [DEPTH]
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    entry_vld = vld_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_rd[i] = mem_q[i].rd;
    end
  end

  // Caller guarantees push only when !full and pop only when !empty, so the
  // write and read slots never coincide within one cycle.
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_req;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the WB stage (priority) and buffered MDU
// results; a starvation timer forces a one-cycle pipeline stall to drain the FIFO head.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
);

  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  wb_req_t               push_req;
  wb_req_t               fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH-1:0]      entry_vld;
  logic [REG_ADDR_W-1:0] entry_rd [DEPTH];
  logic                  push;
  logic                  pop;
  logic                  mdu_ready;
  wb_src_e               src;

  logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  stall_q, stall_d;

  wb_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_req  (push_req),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .entry_vld (entry_vld),
    .entry_rd  (entry_rd)
  );

  // Ready comes only from the registered fill level, so a same-cycle dequeue
  // never opens a slot for the MDU.
  assign mdu_ready     = rst_n && !fifo_full;
  assign bus.mdu_ready = mdu_ready;
  assign push          = bus.mdu_valid && mdu_ready && (bus.mdu_rd != '0);
  assign push_req      = '{rd: bus.mdu_rd, data: bus.mdu_data};
  assign bus.stall_o   = stall_q;

  always_comb begin
    src = SRC_NONE;
    if (rst_n) begin
      if (stall_q && !fifo_empty) begin
        src = SRC_MDU;
      end else if (bus.wb_enable && (bus.wb_rd != '0)) begin
        src = SRC_PIPE;
      end else if (!fifo_empty) begin
        src = SRC_MDU;
      end
    end
  end

  assign pop = (src == SRC_MDU);

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_rd    = '0;
    bus.rf_wdata = '0;
    case (src)
      SRC_PIPE: begin
        bus.rf_we    = 1'b1;
        bus.rf_rd    = bus.wb_rd;
        bus.rf_wdata = bus.wb_data;
      end
      SRC_MDU: begin
        bus.rf_we    = 1'b1;
        bus.rf_rd    = fifo_head.rd;
        bus.rf_wdata = fifo_head.data;
      end
      default: ;
    endcase
  end

  // The stall cycle always dequeues, which clears the counter, so stall_q
  // can never assert in back-to-back cycles.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    stall_d    = 1'b0;
    if (fifo_empty || pop) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == WW'(MAX_WAIT - 1)) begin
      wait_cnt_d = '0;
      stall_d    = 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    bus.pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) begin
        bus.pending_mask[entry_rd[i]] = 1'b1;
      end
    end
    bus.pending_mask[0] = 1'b0;
    if (!rst_n) begin
      bus.pending_mask = '0;
    end
  end

endmodule
